// File: rtl/s_axi_lite_regs.sv
// AXI4-Lite slave register file; every committed write is echoed to user logic as a one-cycle strobe.
// Optional macro S_AXI_LITE_STATUS_EN makes register REG_NUM-1 a read-only view of the status input.
module s_axi_lite_regs #(
   parameter int DWIDTH  = 32,
   parameter int REGSIZE = 8,
   parameter int REG_NUM = 16
) (
   input  logic                 clk,
   input  logic                 xrst,
   input  logic                 awvalid,
   input  logic [REGSIZE-1:0]   awaddr,
   input  logic [2:0]           awprot,
   output logic                 awready,
   input  logic                 wvalid,
   input  logic [DWIDTH-1:0]    wdata,
   input  logic [DWIDTH/8-1:0]  wstrb,
   output logic                 wready,
   output logic                 bvalid,
   output logic [1:0]           bresp,
   input  logic                 bready,
   input  logic                 arvalid,
   input  logic [REGSIZE-1:0]   araddr,
   input  logic [2:0]           arprot,
   output logic                 arready,
   output logic                 rvalid,
   output logic [DWIDTH-1:0]    rdata,
   output logic [1:0]           rresp,
   input  logic                 rready,
   input  logic [DWIDTH-1:0]    status,
   output logic                 wr_en,
   output logic [REGSIZE-3:0]   wr_idx,
   output logic [DWIDTH-1:0]    wr_data
);
   localparam int IW = REGSIZE - 2;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t            w_state, w_state_nxt;
   r_state_t            r_state, r_state_nxt;
   logic [DWIDTH-1:0]   regs [REG_NUM];
   logic                aw_held, w_held, commit, w_ok, ar_ok;
   logic [IW-1:0]       aw_idx, ar_idx;
   logic [DWIDTH-1:0]   wdata_q, cur_val, merged, rd_val;
   logic [DWIDTH/8-1:0] wstrb_q;
   logic                unused_bits;

   assign ar_idx = araddr[REGSIZE-1:2];

`ifdef S_AXI_LITE_STATUS_EN
   assign w_ok        = (32'(aw_idx) < 32'(REG_NUM - 1));
   assign ar_ok       = (32'(ar_idx) < 32'(REG_NUM));
   assign unused_bits = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};
`else
   assign w_ok        = (32'(aw_idx) < 32'(REG_NUM));
   assign ar_ok       = (32'(ar_idx) < 32'(REG_NUM));
   assign unused_bits = ^{awprot, arprot, awaddr[1:0], araddr[1:0], status};
`endif

   // Index compares instead of direct array indexing keep out-of-range indices harmless.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
      cur_val = '0;
      rd_val  = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         if (aw_idx == IW'(i)) cur_val = regs[i];
         if (ar_idx == IW'(i)) rd_val  = regs[i];
      end
      merged = cur_val;
      for (int b = 0; b < DWIDTH/8; b++)
         if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
   end

   always_comb begin
      w_state_nxt = w_state;
      awready     = 1'b0;
      wready      = 1'b0;
      commit      = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = !aw_held;
            wready  = !w_held;
            commit  = aw_held && w_held;
            if (commit) w_state_nxt = W_RESP;
         end
         W_RESP: if (bvalid && bready) w_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (xrst) begin
         w_state <= W_IDLE;
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         aw_idx  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         bvalid  <= 1'b0;
         bresp   <= RESP_OKAY;
         wr_en   <= 1'b0;
         wr_idx  <= '0;
         wr_data <= '0;
         // NOTE: the register file has a defined reset value, so it is built from resettable flops, not RAM.
         for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      end else begin
         // NOTE: state updates use <= so every flop samples pre-edge values; a colliding read sees the old data.
         w_state <= w_state_nxt;
         wr_en   <= 1'b0;
         if (awvalid && awready) begin
            aw_held <= 1'b1;
            aw_idx  <= awaddr[REGSIZE-1:2];
         end
         if (wvalid && wready) begin
            w_held  <= 1'b1;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end
         if (commit) begin
            bresp <= w_ok ? RESP_OKAY : RESP_SLVERR;
            if (w_ok) begin
               wr_en   <= 1'b1;
               wr_idx  <= aw_idx;
               wr_data <= merged;
               for (int i = 0; i < REG_NUM; i++)
                  if (aw_idx == IW'(i)) regs[i] <= merged;
            end
         end
         // bvalid rises one cycle after the commit edge
         if (w_state == W_RESP && !bvalid) bvalid <= 1'b1;
         if (bvalid && bready) begin
            bvalid  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
         end
      end
   end

   assign arready = (r_state == R_IDLE);
   assign rvalid  = (r_state == R_DATA);

   always_comb begin
      r_state_nxt = r_state;
      case (r_state)
         R_IDLE: if (arvalid) r_state_nxt = R_DATA;
         R_DATA: if (rready)  r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (xrst) begin
         r_state <= R_IDLE;
         rdata   <= '0;
         rresp   <= RESP_OKAY;
      end else begin
         r_state <= r_state_nxt;
         if (arvalid && arready) begin
            if (ar_ok) begin
               rdata <= rd_val;
               rresp <= RESP_OKAY;
            end else begin
               rdata <= '0;
               rresp <= RESP_SLVERR;
            end
`ifdef S_AXI_LITE_STATUS_EN
            if (ar_idx == IW'(REG_NUM - 1)) rdata <= status;
`endif
         end
      end
   end
endmodule

// File: tb/tb_s_axi_lite_regs.sv
// Self-checking bench for s_axi_lite_regs: a transaction-level register model feeds expectation
// queues that one negedge compare process checks; directed tests add literal expectations.
module tb_s_axi_lite_regs;
   localparam int DW = 32;
   localparam int RS = 8;
   localparam int RN = 16;
   localparam logic [31:0] STATUS_WORD = 32'hCAFE0001;

   logic          clk = 1'b0;
   logic          xrst;
   logic          awvalid, wvalid, bready, arvalid, rready;
   logic [RS-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic [DW-1:0] wdata, status;
   logic [3:0]    wstrb;
   logic          awready, wready, bvalid, arready, rvalid, wr_en;
   logic [1:0]    bresp, rresp;
   logic [DW-1:0] rdata, wr_data;
   logic [RS-3:0] wr_idx;

   always #5 clk = ~clk;

   s_axi_lite_regs #(.DWIDTH(DW), .REGSIZE(RS), .REG_NUM(RN)) dut (
      .clk(clk), .xrst(xrst),
      .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awready(awready),
      .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
      .bvalid(bvalid), .bresp(bresp), .bready(bready),
      .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arready(arready),
      .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
      .status(status), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
   );

   typedef struct packed { logic [RS-3:0] idx; logic [31:0] data; } wr_exp_t;
   typedef struct packed { logic [31:0] data; logic [1:0] resp; } rd_exp_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [RN];
   wr_exp_t     exp_wr [$];
   logic [1:0]  exp_b  [$];
   rd_exp_t     exp_r  [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit writable(input int idx);
`ifdef S_AXI_LITE_STATUS_EN
      return idx < RN - 1;
`else
      return idx < RN;
`endif
   endfunction

   task automatic expect_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int      idx = int'(addr) / 4;
      wr_exp_t e;
      if (writable(idx)) begin
         logic [31:0] v = model[idx];
         for (int b = 0; b < 4; b++) if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
         model[idx] = v;
         e.idx  = (RS-2)'(idx);
         e.data = v;
         exp_wr.push_back(e);
         exp_b.push_back(2'b00);
      end else begin
         exp_b.push_back(2'b10);
      end
   endtask

   task automatic expect_read(input logic [7:0] addr);
      int      idx = int'(addr) / 4;
      rd_exp_t e;
      e.data = 32'h0;
      e.resp = 2'b10;
      if (idx < RN) begin
         e.data = model[idx];
         e.resp = 2'b00;
      end
`ifdef S_AXI_LITE_STATUS_EN
      if (idx == RN - 1) e.data = STATUS_WORD;
`endif
      exp_r.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_aw(input logic [7:0] addr, input int dly);
      logic ok = 1'b0;
      int   n  = 0;
      repeat (dly) step();
      awvalid = 1'b1;
      awaddr  = addr;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = awready;
         step();
         n++;
      end
      awvalid = 1'b0;
      check("aw_accepted", 32'(ok), 32'd1);
   endtask

   task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
      logic ok = 1'b0;
      int   n  = 0;
      repeat (dly) step();
      wvalid = 1'b1;
      wdata  = data;
      wstrb  = strb;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = wready;
         step();
         n++;
      end
      wvalid = 1'b0;
      check("w_accepted", 32'(ok), 32'd1);
   endtask

   task automatic drive_ar(input logic [7:0] addr);
      logic ok = 1'b0;
      int   n  = 0;
      arvalid = 1'b1;
      araddr  = addr;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = arready;
         step();
         n++;
      end
      arvalid = 1'b0;
      check("ar_accepted", 32'(ok), 32'd1);
   endtask

   task automatic wait_b(input int hold, output logic [1:0] resp);
      int n = 0;
      while (!bvalid && n < 50) begin step(); n++; end
      check("b_arrived", 32'(bvalid), 32'd1);
      resp = bresp;
      repeat (hold) begin
         check("bvalid_hold", 32'(bvalid), 32'd1);
         check("aw_blocked", 32'(awready), 32'd0);
         check("w_blocked", 32'(wready), 32'd0);
         step();
      end
      bready = 1'b1;
      step();
      bready = 1'b0;
   endtask

   task automatic wait_r(input int hold, output logic [31:0] data, output logic [1:0] resp);
      int n = 0;
      while (!rvalid && n < 50) begin step(); n++; end
      check("r_arrived", 32'(rvalid), 32'd1);
      data = rdata;
      resp = rresp;
      repeat (hold) begin
         check("rvalid_hold", 32'(rvalid), 32'd1);
         check("ar_blocked", 32'(arready), 32'd0);
         step();
      end
      rready = 1'b1;
      step();
      rready = 1'b0;
   endtask

   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_hold, output logic [1:0] br);
      expect_write(addr, data, strb);
      fork
         drive_aw(addr, aw_dly);
         drive_w(data, strb, w_dly);
      join
      wait_b(b_hold, br);
   endtask

   task automatic axi_read(input logic [7:0] addr, input int r_hold, output logic [31:0] d,
                           output logic [1:0] r);
      expect_read(addr);
      drive_ar(addr);
      wait_r(r_hold, d, r);
   endtask

   // Compare process: every cycle a response or strobe is visible, it must match the model queue head.
   logic    b_active = 1'b0;
   logic    r_active = 1'b0;
   logic [1:0] cur_b;
   rd_exp_t cur_r;
   wr_exp_t cur_w;

   initial begin
      forever begin
         @(negedge clk);
         if (xrst) begin
            b_active = 1'b0;
            r_active = 1'b0;
         end else begin
            if (wr_en) begin
               if (exp_wr.size() == 0) check("wr_en_unexpected", 32'(wr_en), 32'd0);
               else begin
                  cur_w = exp_wr.pop_front();
                  check("wr_idx", 32'(wr_idx), 32'(cur_w.idx));
                  check("wr_data", wr_data, cur_w.data);
               end
            end
            if (bvalid) begin
               if (!b_active) begin
                  if (exp_b.size() == 0) begin
                     check("bvalid_unexpected", 32'(bvalid), 32'd0);
                     cur_b = bresp;
                  end else cur_b = exp_b.pop_front();
                  b_active = 1'b1;
               end
               check("bresp", 32'(bresp), 32'(cur_b));
               if (bready) b_active = 1'b0;
            end
            if (rvalid) begin
               if (!r_active) begin
                  if (exp_r.size() == 0) begin
                     check("rvalid_unexpected", 32'(rvalid), 32'd0);
                     cur_r.data = rdata;
                     cur_r.resp = rresp;
                  end else cur_r = exp_r.pop_front();
                  r_active = 1'b1;
               end
               check("rdata", rdata, cur_r.data);
               check("rresp", 32'(rresp), 32'(cur_r.resp));
               if (rready) r_active = 1'b0;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r, br;
      xrst = 1'b1;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      awaddr = '0; araddr = '0; awprot = 3'b010; arprot = 3'b101;
      wdata = '0; wstrb = '0; status = STATUS_WORD;
      for (int i = 0; i < RN; i++) model[i] = 32'h0;
      repeat (3) step();

      check("rst_awready", 32'(awready), 32'd1);
      check("rst_wready", 32'(wready), 32'd1);
      check("rst_arready", 32'(arready), 32'd1);
      check("rst_bvalid", 32'(bvalid), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_resps", {28'd0, bresp, rresp}, 32'd0);
      check("rst_wr_idx", 32'(wr_idx), 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      xrst = 1'b0;
      step();

      // Same-cycle AW/W, then read back (addr[1:0] ignored on the second read)
      axi_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, br);
      check("w04_bresp", 32'(br), 32'd0);
      axi_read(8'h04, 0, d, r);
      check("r04_data", d, 32'hDEADBEEF);
      check("r04_resp", 32'(r), 32'd0);
      axi_read(8'h07, 2, d, r);
      check("r07_data", d, 32'hDEADBEEF);

      // W three cycles ahead of AW onto a preloaded register
      axi_write(8'h08, 32'hAABBCCDD, 4'hF, 2, 0, 0, br);
      expect_write(8'h08, 32'h12345678, 4'b0101);
      fork
         drive_w(32'h12345678, 4'b0101, 0);
         begin
            for (int k = 0; k < 3; k++) begin
               check("aw_ready_wait", 32'(awready), 32'd1);
               check("no_early_commit", 32'(wr_en), 32'd0);
               check("no_early_bvalid", 32'(bvalid), 32'd0);
               step();
            end
            drive_aw(8'h08, 0);
         end
      join
      wait_b(0, br);
      axi_read(8'h08, 0, d, r);
      check("reg2_merge", d, 32'hAA34CC78);

      // Empty strobe still reports a commit and leaves data alone
      axi_write(8'h04, 32'hFFFFFFFF, 4'h0, 0, 0, 0, br);
      axi_read(8'h04, 0, d, r);
      check("strb0_unchanged", d, 32'hDEADBEEF);

      // Out-of-range address
      axi_write(8'h40, 32'h01020304, 4'hF, 0, 0, 0, br);
      check("oor_bresp", 32'(br), 32'd2);
      axi_read(8'h40, 0, d, r);
      check("oor_rdata", d, 32'd0);
      check("oor_rresp", 32'(r), 32'd2);

      // Delayed bready, then a following write is accepted
      axi_write(8'h10, 32'h0BAD0BAD, 4'hF, 0, 0, 5, br);
      axi_write(8'h14, 32'h00C0FFEE, 4'b0011, 0, 0, 0, br);
      axi_read(8'h14, 0, d, r);
      check("reg5_low_half", d, 32'h0000FFEE);

      // Read accepted on the commit edge of a write to the same register returns the old value
      axi_write(8'h0C, 32'h11111111, 4'hF, 0, 0, 0, br);
      expect_read(8'h0C);
      expect_write(8'h0C, 32'h22222222, 4'hF);
      awvalid = 1'b1; awaddr = 8'h0C; wvalid = 1'b1; wdata = 32'h22222222; wstrb = 4'hF;
      @(negedge clk);
      check("coll_aw_w_ready", 32'(awready & wready), 32'd1);
      step();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1; araddr = 8'h0C;
      @(negedge clk);
      check("coll_arready", 32'(arready), 32'd1);
      step();
      arvalid = 1'b0;
      fork
         wait_b(0, br);
         wait_r(1, d, r);
      join
      check("coll_old_value", d, 32'h11111111);
      axi_read(8'h0C, 0, d, r);
      check("coll_new_value", d, 32'h22222222);

`ifdef S_AXI_LITE_STATUS_EN
      axi_read(8'h3C, 0, d, r);
      check("status_read", d, STATUS_WORD);
      axi_write(8'h3C, 32'h5555AAAA, 4'hF, 0, 0, 0, br);
      check("status_wr_bresp", 32'(br), 32'd2);
      axi_read(8'h3C, 0, d, r);
      check("status_unchanged", d, 32'hCAFE0001);
`else
      axi_write(8'h3C, 32'h5555AAAA, 4'hF, 0, 0, 0, br);
      check("reg15_bresp", 32'(br), 32'd0);
      axi_read(8'h3C, 0, d, r);
      check("reg15_rw", d, 32'h5555AAAA);
`endif

      // Reset while a read response is stalled
      expect_read(8'h04);
      drive_ar(8'h04);
      step();
      step();
      check("pre_rst_rvalid", 32'(rvalid), 32'd1);
      xrst = 1'b1;
      step();
      xrst = 1'b0;
      check("post_rst_rvalid", 32'(rvalid), 32'd0);
      check("post_rst_arready", 32'(arready), 32'd1);
      exp_r.delete();
      exp_b.delete();
      exp_wr.delete();
      for (int i = 0; i < RN; i++) model[i] = 32'h0;
      step();
      for (int i = 0; i < RN; i++) axi_read(8'(i * 4), 0, d, r);
      axi_read(8'h04, 0, d, r);
      check("reg1_cleared", d, 32'h0);

      repeat (3) step();
      check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
      check("b_queue_drained", 32'(exp_b.size()), 32'd0);
      check("r_queue_drained", 32'(exp_r.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
